// File: rtl/fwc_pkg.sv
// Shared definitions for the DDFS frequency-word sweep controller.
package fwc_pkg;

    localparam int FW_WIDTH_DEF    = 7;
    localparam int DEB_CYCLES_DEF  = 50000;
    localparam int DWELL_WIDTH_DEF = 16;

    // Controller operating states.
    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        UP     = 2'd1,
        DOWN   = 2'd2
    } state_t;

endpackage

// File: rtl/fw_sweep_ctrl_key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, level debouncer and a one-cycle
// pulse on each accepted press (accepted level going 1 -> 0).
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk_div,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the raw key level into the clk_div domain; idle is released (1).
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES cycles in a row.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
                press <= ~sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fw_sweep_ctrl.sv
// Frequency-word controller for the DDFS: manual stepping from debounced keys,
// or automatic sawtooth/triangle sweep between fw_min and fw_max with a
// programmable dwell of dwell+1 cycles per step.
//
// state  | meaning
// MANUAL | fw changes only on debounced up/down presses
// UP     | sweeping upward (or holding on degenerate limits)
// DOWN   | triangle sweep, downward leg
module fw_sweep_ctrl
    import fwc_pkg::*;
#(
    parameter int FW_WIDTH    = FW_WIDTH_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   clk_div,
    input  logic                   rst_n,
    input  logic                   key_up_n,
    input  logic                   key_down_n,
    input  logic                   sweep_en,
    input  logic                   sweep_tri,
    input  logic [FW_WIDTH-1:0]    fw_min,
    input  logic [FW_WIDTH-1:0]    fw_max,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [FW_WIDTH-1:0]    fw,
    output logic                   step_pulse,
    output logic                   sweep_active,
    output logic                   dir_down
);

    state_t                 state;
    state_t                 state_nxt;
    logic [FW_WIDTH-1:0]    fw_nxt;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [DWELL_WIDTH-1:0] dwell_cnt_nxt;
    logic                   press_up;
    logic                   press_down;
    logic                   limits_flat;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .key_n   (key_up_n),
        .press   (press_up)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .key_n   (key_down_n),
        .press   (press_down)
    );

    // min == max holds the value, min > max is invalid and pins fw to fw_min;
    // both collapse to "load fw_min, keep direction".
    assign limits_flat = (fw_min >= fw_max);

    // Next-state, dwell counter and frequency-word datapath.
    always_comb begin
        state_nxt     = state;
        fw_nxt        = fw;
        dwell_cnt_nxt = dwell_cnt;
        if (!sweep_en) begin
            state_nxt     = MANUAL;
            dwell_cnt_nxt = '0;
            if (state == MANUAL) begin
                if (press_up && !press_down) begin
                    if (fw < fw_min)       fw_nxt = fw_min;
                    else if (fw >= fw_max) fw_nxt = fw_max;
                    else                   fw_nxt = fw + 1'b1;
                end else if (press_down && !press_up) begin
                    if (fw > fw_max)       fw_nxt = fw_max;
                    else if (fw <= fw_min) fw_nxt = fw_min;
                    else                   fw_nxt = fw - 1'b1;
                end
            end
        end else begin
            case (state)
                MANUAL: begin
                    state_nxt     = UP;
                    fw_nxt        = fw_min;
                    dwell_cnt_nxt = '0;
                end
                UP: begin
                    if (dwell_cnt == dwell) begin
                        dwell_cnt_nxt = '0;
                        if (limits_flat) begin
                            fw_nxt = fw_min;
                        end else if (fw > fw_max) begin
                            if (sweep_tri) begin
                                fw_nxt    = fw_max;
                                state_nxt = DOWN;
                            end else begin
                                fw_nxt = fw_min;
                            end
                        end else if (fw < fw_min) begin
                            fw_nxt = fw_min;
                        end else if (fw < fw_max) begin
                            fw_nxt = fw + 1'b1;
                        end else if (sweep_tri) begin
                            fw_nxt    = fw - 1'b1;
                            state_nxt = DOWN;
                        end else begin
                            fw_nxt = fw_min;
                        end
                    end else begin
                        dwell_cnt_nxt = dwell_cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (dwell_cnt == dwell) begin
                        dwell_cnt_nxt = '0;
                        if (limits_flat) begin
                            fw_nxt = fw_min;
                        end else if (fw > fw_max) begin
                            if (sweep_tri) begin
                                fw_nxt = fw_max;
                            end else begin
                                fw_nxt    = fw_min;
                                state_nxt = UP;
                            end
                        end else if (fw < fw_min) begin
                            fw_nxt    = fw_min;
                            state_nxt = UP;
                        end else if (fw > fw_min) begin
                            fw_nxt = fw - 1'b1;
                        end else begin
                            fw_nxt    = fw + 1'b1;
                            state_nxt = UP;
                        end
                    end else begin
                        dwell_cnt_nxt = dwell_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt     = MANUAL;
                    dwell_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Register state, counter, fw and the change strobe.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MANUAL;
            fw         <= '0;
            dwell_cnt  <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            fw         <= fw_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            step_pulse <= (fw_nxt != fw);
        end
    end

    assign sweep_active = (state == UP) || (state == DOWN);
    assign dir_down     = (state == DOWN);

endmodule

// File: doc/fw_sweep_ctrl.md
Name: fw_sweep_ctrl

Overview:
- Upstream control stage for the DDFS core; produces the 7-bit frequency word `fw` that sets the DDFS phase increment (fw+1).
- Two operating modes:
  - Manual: debounced up/down pushbuttons step `fw` one unit per press.
  - Sweep: `fw` steps automatically between programmable limits, as a sawtooth or a triangle, with a programmable dwell time per step.
- Runs on the divided sample clock so that frequency changes align with DDFS counter updates.

Parameters:
- FW_WIDTH, 7, width of the frequency word.
- DEB_CYCLES, 50000, number of consecutive stable cycles needed to accept a key level change (minimum 2).
- DWELL_WIDTH, 16, width of the dwell counter and `dwell` input.

Ports:
- clk_div  in  1  sample clock, same net as the DDFS counter clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_up_n  in  1  raw pushbutton, active-low, asynchronous to clk_div.
- key_down_n  in  1  raw pushbutton, active-low, asynchronous to clk_div.
- sweep_en  in  1  1 = sweep mode, 0 = manual mode; synchronous level.
- sweep_tri  in  1  0 = sawtooth sweep (up, wrap to min); 1 = triangle sweep (up/down).
- fw_min  in  FW_WIDTH  lower sweep/manual limit.
- fw_max  in  FW_WIDTH  upper sweep/manual limit.
- dwell  in  DWELL_WIDTH  extra cycles per step; the step period is dwell+1 cycles.
- fw  out  FW_WIDTH  frequency word to the DDFS; registered.
- step_pulse  out  1  one-cycle pulse on each cycle in which fw changes.
- sweep_active  out  1  high while the FSM is in UP or DOWN.
- dir_down  out  1  high while in DOWN.

Behaviour:
- Reset (asynchronous): fw=0, state=MANUAL, dwell counter=0, debouncers idle (released), step_pulse=0, sweep_active=0, dir_down=0.
- Key path (per key):
  - A 2-flop synchronizer feeds a debouncer.
  - Debounce counter: cleared whenever the synced level equals the accepted level; increments while they differ.
  - When the counter reaches DEB_CYCLES-1 while the levels still differ, the accepted level toggles.
  - A 1→0 toggle of the accepted level produces a one-cycle `press` pulse.
  - Glitches shorter than DEB_CYCLES cycles produce nothing.
  - fw updates on the edge after `press`.
- State MANUAL:
  - Up press: if fw<fw_min, fw=fw_min; elif fw>=fw_max, fw=fw_max; else fw+1.
  - Down press: if fw>fw_max, fw=fw_max; elif fw<=fw_min, fw=fw_min; else fw-1.
  - Simultaneous up and down press pulses in the same cycle are ignored.
  - step_pulse asserts only if the new fw differs from the old fw.
- MANUAL→UP: on the first cycle sweep_en=1 (sampled while in MANUAL). fw=fw_min, dwell counter=0; step_pulse asserts if fw changed.
- Any state→MANUAL: on any cycle sweep_en=0. fw holds its current value; the dwell counter clears.
- Dwell:
  - In UP/DOWN the counter increments each cycle.
  - When it equals `dwell`, a step occurs and the counter clears.
  - dwell=0 steps every cycle.
  - A change to `dwell` takes effect on the next comparison. If dwell is lowered below the current count, the counter runs to wrap-around at 2^DWELL_WIDTH-1; this is accepted.
- Step in UP:
  - If fw<fw_max: fw+1.
  - Else if sawtooth: fw=fw_min.
  - Else (triangle): fw-1, go to DOWN.
- Step in DOWN:
  - If fw>fw_min: fw-1.
  - Else: fw+1, go to UP.
- Limits changed during a sweep:
  - If fw>fw_max, the next step loads fw_max and goes to DOWN (triangle) or loads fw_min (sawtooth).
  - If fw<fw_min, the next step loads fw_min and goes to UP.
- Degenerate limits:
  - fw_min==fw_max: fw is held at that value; no step_pulse after entry; the state stays UP.
  - fw_min>fw_max (invalid): fw is forced to fw_min each step; no direction change; step_pulse only if the value changes.
- Arithmetic: all fw math is unsigned FW_WIDTH; no wrap-around is possible because of the limit checks.
- Keys are ignored in UP/DOWN, but the debouncers keep running so that no stale press fires on return to MANUAL.
- Reset mid-operation returns everything to the reset values immediately; no pending press survives.

Decomposition:
- Shared package fwc_pkg:
  - state enum {MANUAL, UP, DOWN}.
  - FW_WIDTH default constant.
- Sub-module key_debounce (synchronizer + debouncer + falling-edge pulse, parameter DEB_CYCLES), instantiated twice.
- FSM, dwell counter and fw datapath live in fw_sweep_ctrl.

Test Plan:
1. Reset: run a triangle sweep, pulse rst_n low for 3 cycles → fw=0, sweep_active=0, dir_down=0, step_pulse=0 during and immediately after reset.
2. Manual debounce (DEB_CYCLES=4, fw_min=2, fw_max=5, fw=0): 2-cycle low glitch on key_up_n → fw stays 0. Four held presses → fw sequence 2,3,4,5. A fifth press → fw=5 with no step_pulse. Both keys pressed in the same cycle → no change.
3. Sawtooth (min=10, max=12, dwell=2, sweep_en 0→1) → fw=10 from the entry cycle. Then fw holds each value 3 cycles: 10,11,12,10,11…; step_pulse every 3rd cycle.
4. Triangle (min=10, max=12, dwell=0) → fw per cycle 10,11,12,11,10,11,12…; dir_down high exactly while the sequence is decreasing.
5. Invalid/degenerate limits: min=20, max=15 in sweep → fw=20 constant, no step_pulse after entry. min=max=8 → fw=8 constant, sweep_active=1.
6. Mode exit: sweep_en 1→0 with fw=11 → fw holds 11, state MANUAL. A key press made during the sweep fires no stale press. A new key_down press → fw=10.
